pcm_frame_sync: RTL and testbench

PCM_FRAME_SYNC -- requirements
Module: pcm_frame_sync

---
 rtl/pcm_frame_sync.sv | 231 +++++++++++++++++++++++
 tb/tb_pcm_frame_sync.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_frame_sync.sv
// PCM frame synchroniser: recovers NRZ bits from a raw line, hunts for the frame sync word in
// either polarity, and once locked emits the frame as WORD_BITS-wide words with start-of-frame.
module pcm_frame_sync #(
   parameter int                    CLK_HZ          = 10240000,
   parameter int                    BIT_RATE        = 51200,
   parameter int                    WORD_BITS       = 8,
   parameter int                    FRAME_WORDS     = 128,
   parameter int                    SYNC_BITS       = 26,
   parameter logic [SYNC_BITS-1:0]  SYNC_PATTERN    = 26'b00000101_01111001_10110111_11,
   parameter int                    MAX_ERRS        = 1,
   parameter int                    VERIFY_FRAMES   = 2,
   parameter int                    FLYWHEEL_FRAMES = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           rxd,
   output logic [WORD_BITS-1:0]           tx_data,
   output logic                           tx_valid,
   output logic                           tx_sof,
   output logic                           lock,
   output logic [1:0]                     state,
   output logic                           inverted,
   output logic [$clog2(SYNC_BITS+1)-1:0] sync_errs
);

   localparam int CYC        = CLK_HZ / BIT_RATE;
   localparam int FRAME_BITS = FRAME_WORDS * WORD_BITS;
   localparam int TW         = (CYC > 1) ? $clog2(CYC) : 1;
   localparam int PW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int WW         = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam int EW         = $clog2(SYNC_BITS + 1);
   localparam int HW         = $clog2(VERIFY_FRAMES + 1);
   localparam int MW         = $clog2(FLYWHEEL_FRAMES + 1);

   localparam logic [TW-1:0] T_LAST = TW'(CYC - 1);
   localparam logic [TW-1:0] T_MID  = TW'(CYC / 2);
   localparam logic [PW-1:0] P_LAST = PW'(FRAME_BITS - 1);
   localparam logic [WW-1:0] W_LAST = WW'(WORD_BITS - 1);
   localparam logic [EW-1:0] E_MAX  = EW'(MAX_ERRS);
   localparam logic [EW-1:0] E_FULL = EW'(SYNC_BITS);
   localparam logic [HW-1:0] H_TGT  = HW'(VERIFY_FRAMES);
   localparam logic [MW-1:0] M_TGT  = MW'(FLYWHEEL_FRAMES);

   typedef enum logic [1:0] {
      SEARCH   = 2'b00,
      VERIFY   = 2'b01,
      LOCK     = 2'b10,
      FLYWHEEL = 2'b11
   } state_t;

   function automatic logic [EW-1:0] popcount(input logic [SYNC_BITS-1:0] v);
      logic [EW-1:0] n;
      n = '0;
      for (int i = 0; i < SYNC_BITS; i++) n = n + EW'(v[i]);
      return n;
   endfunction

   logic                 sync1, sync2, hist1, hist2, bit_filt;
   logic                 filt_edge, strobe, eval;
   logic [TW-1:0]        timer;
   logic [SYNC_BITS-1:0] shift_reg;
   logic [EW-1:0]        fill;
   logic [PW-1:0]        pos;
   logic [WW-1:0]        wpos;

   state_t               cur, nxt;
   logic [HW-1:0]        hits, hits_nxt;
   logic [MW-1:0]        miss, miss_nxt;
   logic                 inv_nxt, accept, emit, emit_sof;
   logic [EW-1:0]        errs, inv_errs, chk_errs, errs_nxt;
   logic                 hit;
   logic [WORD_BITS-1:0] word;

   // Filtered bit moves only when three successive synchronised samples agree.
   assign filt_edge = (sync2 == hist1) && (hist1 == hist2) && (sync2 != bit_filt);
   assign strobe    = (timer == T_MID);

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         hist1    <= 1'b0;
         hist2    <= 1'b0;
         bit_filt <= 1'b0;
         timer    <= '0;
      end else begin
         sync1 <= rxd;
         sync2 <= sync1;
         hist1 <= sync2;
         hist2 <= hist1;
         if (filt_edge) begin
            bit_filt <= sync2;
            timer    <= '0;
         end else begin
            timer <= (timer == T_LAST) ? '0 : timer + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         fill      <= '0;
         eval      <= 1'b0;
      end else begin
         eval <= strobe;
         if (strobe) begin
            shift_reg <= {shift_reg[SYNC_BITS-2:0], bit_filt};
            if (fill != E_FULL) fill <= fill + EW'(1);
         end
      end
   end

   // Bit position within the frame; wpos tracks pos modulo WORD_BITS.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos  <= '0;
         wpos <= '0;
      end else if (eval && accept) begin
         pos  <= '0;
         wpos <= '0;
      end else if (strobe && cur != SEARCH) begin
         pos  <= (pos == P_LAST) ? '0 : pos + PW'(1);
         wpos <= (wpos == W_LAST) ? '0 : wpos + WW'(1);
      end
   end

   assign errs     = popcount(shift_reg ^ SYNC_PATTERN);
   assign inv_errs = popcount(~shift_reg ^ SYNC_PATTERN);
   assign chk_errs = inverted ? inv_errs : errs;
   assign hit      = (chk_errs <= E_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur <= SEARCH;
      else       cur <= nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      nxt      = cur;
      hits_nxt = hits;
      miss_nxt = miss;
      inv_nxt  = inverted;
      errs_nxt = sync_errs;
      accept   = 1'b0;
      if (eval) begin
         unique case (cur)
            SEARCH: begin
               if (fill == E_FULL) begin
                  if (errs <= E_MAX) begin
                     accept   = 1'b1;
                     inv_nxt  = 1'b0;
                     errs_nxt = errs;
                  end else if (inv_errs <= E_MAX) begin
                     accept   = 1'b1;
                     inv_nxt  = 1'b1;
                     errs_nxt = inv_errs;
                  end
                  if (accept) begin
                     hits_nxt = HW'(1);
                     nxt      = (H_TGT <= HW'(1)) ? LOCK : VERIFY;
                  end
               end
            end
            VERIFY: begin
               if (pos == '0) begin
                  errs_nxt = chk_errs;
                  if (hit) begin
                     hits_nxt = hits + HW'(1);
                     if (hits_nxt >= H_TGT) nxt = LOCK;
                  end else begin
                     nxt = SEARCH;
                  end
               end
            end
            LOCK: begin
               if (pos == '0) begin
                  errs_nxt = chk_errs;
                  if (!hit) begin
                     miss_nxt = MW'(1);
                     nxt      = (M_TGT <= MW'(1)) ? SEARCH : FLYWHEEL;
                  end
               end
            end
            FLYWHEEL: begin
               if (pos == '0) begin
                  errs_nxt = chk_errs;
                  if (hit) begin
                     miss_nxt = '0;
                     nxt      = LOCK;
                  end else begin
                     miss_nxt = miss + MW'(1);
                     if (miss_nxt >= M_TGT) nxt = SEARCH;
                  end
               end
            end
         endcase
      end
   end

   // From SEARCH the only route into LOCK is an acceptance, which is always the sof word.
   assign emit     = eval && (nxt == LOCK || nxt == FLYWHEEL) && (cur == SEARCH || wpos == '0);
   assign emit_sof = (cur == SEARCH) || (pos == '0);
   assign word     = shift_reg[SYNC_BITS-1 -: WORD_BITS] ^ {WORD_BITS{inv_nxt}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hits      <= '0;
         miss      <= '0;
         lock      <= 1'b0;
         inverted  <= 1'b0;
         sync_errs <= '0;
         tx_valid  <= 1'b0;
         tx_sof    <= 1'b0;
         tx_data   <= '0;
      end else begin
         hits      <= hits_nxt;
         miss      <= miss_nxt;
         lock      <= (nxt == LOCK) || (nxt == FLYWHEEL);
         inverted  <= inv_nxt;
         sync_errs <= errs_nxt;
         tx_valid  <= emit;
         tx_sof    <= emit && emit_sof;
         if (emit) tx_data <= word;
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_pcm_frame_sync.sv
// Bench for pcm_frame_sync: random framed NRZ streams, frame-level reference model, word scoreboard.
module tb_pcm_frame_sync;

   localparam int CYC  = 16;
   localparam int WB   = 8;
   localparam int FW   = 8;
   localparam int FB   = FW * WB;
   localparam int SB   = 26;
   localparam int MAXE = 1;
   localparam int VF   = 2;
   localparam int FLY  = 3;
   localparam logic [SB-1:0] SYNC = 26'b00000101_01111001_10110111_11;

   logic          clk = 1'b0;
   logic          reset;
   logic          rxd;
   logic [WB-1:0] tx_data;
   logic          tx_valid, tx_sof, lock, inverted;
   logic [1:0]    state;
   logic [4:0]    sync_errs;

   always #5 clk = ~clk;

   pcm_frame_sync #(
      .CLK_HZ(CYC * 100), .BIT_RATE(100), .WORD_BITS(WB), .FRAME_WORDS(FW),
      .SYNC_BITS(SB), .SYNC_PATTERN(SYNC), .MAX_ERRS(MAXE),
      .VERIFY_FRAMES(VF), .FLYWHEEL_FRAMES(FLY)
   ) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_sof(tx_sof), .lock(lock), .state(state), .inverted(inverted), .sync_errs(sync_errs)
   );

   typedef struct { logic [7:0] data; logic sof; } word_t;
   typedef struct { logic [1:0] st; logic lk; logic inv; logic [4:0] errs; } stat_t;

   word_t word_q[$];
   stat_t stat_q[$];
   event  stat_ev;
   int    checks = 0;
   int    failures = 0;

   // Frame-level model: one sync decision per frame, in SEARCH/VERIFY/LOCK/FLYWHEEL terms.
   logic [1:0] m_state;
   int         m_hits, m_miss, m_errs;
   logic       m_inv;
   logic       cur_pol;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 2'd0; m_hits = 0; m_miss = 0; m_errs = 0; m_inv = 1'b0;
   endtask

   function automatic logic model_step(input int k, input logic finv);
      int   e;
      logic h;
      if (m_state == 2'd0) begin
         if (k <= MAXE) begin
            m_inv = finv; m_errs = k; m_hits = 1;
            m_state = (VF <= 1) ? 2'd2 : 2'd1;
         end
      end else begin
         e      = (finv == m_inv) ? k : SB - k;
         m_errs = e;
         h      = (e <= MAXE);
         case (m_state)
            2'd1: if (h) begin m_hits++; if (m_hits >= VF) m_state = 2'd2; end
                  else m_state = 2'd0;
            2'd2: if (!h) begin m_miss = 1; m_state = (m_miss >= FLY) ? 2'd0 : 2'd3; end
            default: if (h) begin m_state = 2'd2; m_miss = 0; end
                     else begin m_miss++; if (m_miss >= FLY) m_state = 2'd0; end
         endcase
      end
      return m_state[1];
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_lock"}, 32'(lock), 32'd0);
      check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_tx_sof"}, 32'(tx_sof), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      check({tag, "_inverted"}, 32'(inverted), 32'd0);
      check({tag, "_sync_errs"}, 32'(sync_errs), 32'd0);
   endtask

   task automatic drive_bit(input logic b, input logic glitch);
      for (int c = 0; c < CYC; c++) begin
         @(negedge clk);
         rxd = (glitch && (c == 7 || c == 8)) ? ~b : b;
      end
   endtask

   // k sync bits flipped, whole frame inverted when finv; drives bits [0, stop_at).
   task automatic send_frame(input int k, input logic finv, input logic glitch, input int stop_at);
      logic [FB-1:0] fb, line;
      logic [SB-1:0] flipped;
      logic          emit;
      int            n, idx;
      fb = {SYNC, 38'({$urandom(), $urandom()})};
      flipped = '0;
      n = 0;
      while (n < k) begin
         idx = $urandom_range(SB - 1, 0);
         if (!flipped[idx]) begin
            flipped[idx] = 1'b1;
            fb[FB-1-idx] = ~fb[FB-1-idx];
            n++;
         end
      end
      line = fb ^ {FB{finv}};
      emit = model_step(k, finv);
      if (emit)
         for (int w = 0; w < FW; w++)
            word_q.push_back('{line[FB-1-WB*w -: WB] ^ {WB{m_inv}}, (w == 0)});
      stat_q.push_back('{m_state, m_state[1], m_inv, 5'(m_errs)});
      for (int b = 0; b < stop_at; b++) begin
         drive_bit(line[FB-1-b], glitch && ($urandom_range(1, 0) == 1));
         if (b == 40) -> stat_ev;
      end
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
   endtask

   // Word monitor: every tx_valid pulse must match the head of the scoreboard.
   initial begin
      word_t w;
      forever begin
         @(negedge clk);
         if (!reset && tx_valid) begin
            if (word_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_word: got tx_data=0x%02h tx_sof=%0d, expected no word", tx_data, tx_sof);
            end else begin
               w = word_q.pop_front();
               check("tx_data", 32'(tx_data), 32'(w.data));
               check("tx_sof", 32'(tx_sof), 32'(w.sof));
            end
         end
      end
   end

   // Status monitor: mid-frame snapshot of the sync state against the model.
   initial begin
      stat_t s;
      forever begin
         @(stat_ev);
         if (stat_q.size() != 0) begin
            s = stat_q.pop_front();
            check("state", 32'(state), 32'(s.st));
            check("lock", 32'(lock), 32'(s.lk));
            check("inverted", 32'(inverted), 32'(s.inv));
            check("sync_errs", 32'(sync_errs), 32'(s.errs));
         end
      end
   end

   initial begin
      reset = 1'b1;
      rxd   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b0;
      idle_bits(2);

      // Clean acquisition, then single / double sync errors while locked.
      repeat (4) send_frame(0, 1'b0, 1'b0, FB);
      send_frame(1, 1'b0, 1'b0, FB);
      send_frame(2, 1'b0, 1'b0, FB);
      send_frame(0, 1'b0, 1'b0, FB);

      // Three bad syncs lose lock; clean syncs reacquire.
      repeat (3) send_frame(5, 1'b0, 1'b0, FB);
      repeat (3) send_frame(0, 1'b0, 1'b0, FB);

      // Short line glitches must not disturb the data.
      repeat (2) send_frame(0, 1'b0, 1'b1, FB);

      // Polarity flip: flywheel out, re-acquire inverted.
      repeat (6) send_frame(0, 1'b1, 1'b0, FB);
      send_frame(1, 1'b1, 1'b0, FB);
      send_frame(0, 1'b1, 1'b0, FB);

      // Asynchronous reset in the middle of a locked frame.
      send_frame(0, 1'b1, 1'b0, 44);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_reset_outputs("mid_reset");
      word_q.delete();
      stat_q.delete();
      @(negedge clk);
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      idle_bits(2);

      repeat (3) send_frame(0, 1'b0, 1'b0, FB);
      cur_pol = 1'b0;
      for (int f = 0; f < 8; f++) begin
         int kt[6] = '{0, 0, 0, 1, 2, 5};
         if ($urandom_range(7, 0) == 0) cur_pol = ~cur_pol;
         send_frame(kt[$urandom_range(5, 0)], cur_pol, ($urandom_range(3, 0) == 0), FB);
      end

      // Flush the last frame's trailing words without reaching another sync check.
      idle_bits(20);
      repeat (50) @(negedge clk);
      check("words_drained", 32'(word_q.size()), 32'd0);
      check("status_drained", 32'(stat_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
